equiv_sweep_ctrl: RTL
=====================

# equiv_sweep_ctrl

Exhaustive-sweep controller for the single-output benchmark netlists. It drives every one of the 2^N_IN input vectors, one per cycle, into two instances of a combinational function: a reference netlist (original PLA) and a netlist under test (optimized). It samples both outputs, counts mismatches and ON-set minterms, and records the first failing vector. It sits in the verification harness around each benchmark pair and reports a pass/fail verdict through a start/busy/done handshake.

## Interface
- N_IN, default 10: number of function inputs; the sweep covers vectors 0 .. 2^N_IN-1.
- PIPE, default 1: cycles from `vec` changing to the corresponding `y_ref`/`y_dut` being valid. 0 = purely combinational sampling. Legal range 0..3.

- clk  input  1  sole clock, all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
- abort  input  1  terminate the sweep in progress
- vec  output  N_IN  input vector driven to both netlists (bit i drives x_i)
- y_ref  input  1  reference netlist output
- y_dut  input  1  netlist-under-test output
- busy  output  1  high in SWEEP and DRAIN
- done  output  1  one-cycle pulse at completion (not on abort)
- pass  output  1  valid after done; 1 iff mismatch_cnt == 0
- mismatch_cnt  output  N_IN+1  number of vectors where y_ref != y_dut
- onset_cnt  output  N_IN+1  number of vectors where y_ref == 1
- first_fail_vec  output  N_IN  lowest vector that mismatched
- first_fail_valid  output  1  first_fail_vec holds a captured value

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE: `start` clears the counters, first_fail_valid and pass, sets vec = 0, and moves to SWEEP.
- SWEEP: vec increments by 1 each cycle. After vec = 2^N_IN-1 is issued, the FSM moves to DRAIN. If PIPE = 0 it moves directly to DONE.
- DRAIN: lasts PIPE cycles. vec holds 2^N_IN-1. Sampling continues until the last vector's result has been taken.
- DONE: asserts `done` for one cycle, sets pass, then returns to IDLE.
- Sampling uses a PIPE-deep shift of {vec, valid} alongside vec. When the delayed valid is high:
  - mismatch_cnt += (y_ref ^ y_dut)
  - onset_cnt += y_ref
  - On the first mismatch, first_fail_vec = delayed vec and first_fail_valid = 1.
- Counter width is N_IN+1, so the full count 2^N_IN is representable with no wrap. Counters saturate at 2^N_IN (unreachable in legal operation).
- Results hold after DONE or abort until the next accepted `start`.
- `start` while busy or in DONE: ignored.
- `abort` in SWEEP/DRAIN: next state is IDLE and busy drops next cycle. done is not pulsed, pass stays 0, and counters freeze with partial values. In-flight pipeline samples are discarded.
- `abort` and `start` together in IDLE: start wins. abort in IDLE/DONE has no effect.

## Timing
- Reset (async, rst_n low) forces state IDLE and every output to 0: vec, busy, done, pass, mismatch_cnt, onset_cnt, first_fail_vec, first_fail_valid. The pipeline valids are also cleared.
- Reset mid-sweep aborts immediately with no done pulse. The sweep does not resume after reset release.
- Cycle 0 = edge where start is sampled in IDLE.
- From cycle 1: busy = 1 and vec = 0.
- Vector k is on vec during cycle 1+k. Its outputs are sampled at cycle 1+k+PIPE.
- DRAIN occupies cycles 2^N_IN+1 .. 2^N_IN+PIPE.
- done = 1 in cycle 2^N_IN+PIPE+1. busy is 0 in that cycle.
- Final counts and pass are valid in the done cycle and remain stable afterwards.
- Total sweep length is 2^N_IN+PIPE+1 cycles after start. With defaults, done arrives in cycle 1026.
- A new start is accepted the cycle after done, with no dead cycle required.

## Test plan
- **Equivalent pair.** Defaults, y_dut = y_ref = a model of x0&x1 -> done in cycle 1026, pass = 1, mismatch_cnt = 0, onset_cnt = 256, first_fail_valid = 0.
- **Single injected fault.** y_dut = y_ref ^ (delayed vec == 10'h155) -> mismatch_cnt = 1, first_fail_vec = 10'h155, first_fail_valid = 1, pass = 0.
- **Multiple faults and full ON-set.** Constant y_ref = 1 and y_dut = vec[0] -> onset_cnt = 1024 (no wrap in 11 bits), mismatch_cnt = 512, first_fail_vec = 0.
- **Abort and ignored start.** Pulse abort while vec = 100 (PIPE = 1) -> busy low next cycle, no done, counters reflect vectors 0..99 only. Pulse start mid-sweep in a separate run -> no restart; vec continues its increment.
- **Reset and restart.** Deassert rst_n at vec = 500 -> all outputs 0 asynchronously. After release, a fresh start yields the correct full-sweep counts.
- **Pipeline depth.** Repeat the fault test with PIPE = 0 and PIPE = 3 -> done in cycle 1025 and 1028 respectively, with identical counts and first_fail_vec.

Source files
------------

// File: rtl/equiv_sweep_ctrl.sv
// rtl/equiv_sweep_ctrl.sv - exhaustive equivalence sweep controller for single-output netlists
//
// Drives every input vector 0 .. 2^N_IN-1, one per cycle, into a reference and a
// test netlist. It compares the two outputs PIPE cycles later, counts mismatches
// and reference ON-set minterms, and captures the lowest failing vector.
//
// Parameters
//   N_IN  number of function inputs
//   PIPE  netlist latency from vec to y_ref/y_dut (0..3)
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, abort      sweep request (honoured in IDLE) / terminate sweep in progress
//   vec               input vector driven to both netlists
//   y_ref, y_dut      netlist outputs
//   busy, done        sweeping or draining / one-cycle completion pulse
//   pass              no mismatches were seen (valid from the done cycle)
//   mismatch_cnt      vectors with y_ref != y_dut
//   onset_cnt         vectors with y_ref == 1
//   first_fail_vec    lowest mismatching vector
//   first_fail_valid  first_fail_vec holds a captured value
module equiv_sweep_ctrl #(
  parameter int N_IN = 10,
  parameter int PIPE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec,
  input  logic            y_ref,
  input  logic            y_dut,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic [N_IN:0]   onset_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

  localparam logic [N_IN-1:0] VEC_LAST   = '1;
  localparam logic [N_IN:0]   CNT_MAX    = {1'b1, {N_IN{1'b0}}};
  localparam logic [1:0]      DRAIN_LAST = (PIPE > 0) ? 2'(PIPE - 1) : 2'd0;
  // Shift register depth; at least one stage exists even when PIPE = 0, it is simply not tapped.
  localparam int              PD         = (PIPE > 0) ? PIPE : 1;

  state_t state, state_nxt;
  logic [1:0] drain_cnt;

  logic            cur_valid;
  logic            start_acc;
  logic            kill;
  logic [N_IN-1:0] sh_vec [PD];
  logic [PD-1:0]   sh_valid;
  logic [N_IN-1:0] smp_vec;
  logic            smp_valid;
  logic            miss;
  logic [N_IN:0]   mismatch_nxt;
  logic [N_IN:0]   onset_nxt;

  assign cur_valid = (state == S_SWEEP);
  assign start_acc = (state == S_IDLE) && start;
  assign kill      = abort && ((state == S_SWEEP) || (state == S_DRAIN));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      drain_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SWEEP;
      S_SWEEP: begin
        if (abort)                 state_nxt = S_IDLE;
        else if (vec == VEC_LAST)  state_nxt = (PIPE == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (abort)                         state_nxt = S_IDLE;
        else if (drain_cnt == DRAIN_LAST)  state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state == S_SWEEP) || (state == S_DRAIN);
    done = (state == S_DONE);
  end

  // ---------------- sample alignment pipeline ----------------
  // Carries each vector alongside its valid flag so it meets its own netlist result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_valid <= '0;
      for (int i = 0; i < PD; i++) sh_vec[i] <= '0;
    end else begin
      for (int i = 0; i < PD; i++) begin
        sh_vec[i]   <= (i == 0) ? vec : sh_vec[(i == 0) ? 0 : i - 1];
        sh_valid[i] <= kill ? 1'b0 : ((i == 0) ? cur_valid : sh_valid[(i == 0) ? 0 : i - 1]);
      end
    end
  end

  always_comb begin
    smp_vec   = (PIPE == 0) ? vec       : sh_vec[PD-1];
    smp_valid = (PIPE == 0) ? cur_valid : sh_valid[PD-1];
    miss      = smp_valid && (y_ref ^ y_dut);
    mismatch_nxt = mismatch_cnt;
    onset_nxt    = onset_cnt;
    if (miss && (mismatch_cnt != CNT_MAX))                 mismatch_nxt = mismatch_cnt + 1'b1;
    if (smp_valid && y_ref && (onset_cnt != CNT_MAX))      onset_nxt    = onset_cnt + 1'b1;
  end

  // ---------------- vector generator and result registers ----------------
  // The sample already in the last stage is still counted on an abort edge;
  // only samples still in flight behind it are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec              <= '0;
      pass             <= 1'b0;
      mismatch_cnt     <= '0;
      onset_cnt        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (start_acc) begin
      vec              <= '0;
      pass             <= 1'b0;
      mismatch_cnt     <= '0;
      onset_cnt        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      if ((state == S_SWEEP) && !abort && (vec != VEC_LAST)) vec <= vec + 1'b1;
      mismatch_cnt <= mismatch_nxt;
      onset_cnt    <= onset_nxt;
      if (miss && !first_fail_valid) begin
        first_fail_vec   <= smp_vec;
        first_fail_valid <= 1'b1;
      end
      if ((state_nxt == S_DONE) && (state != S_DONE)) pass <= (mismatch_nxt == '0);
    end
  end

endmodule
